// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM peripheral: counter width, duty encoding,
// default prescaler and the waveform compare helper.
package pwm_pkg;

  localparam int         PWM_CNT_W           = 8;
  localparam logic [7:0] PWM_DUTY_FULL       = 8'hFF;
  localparam int         PWM_CLK_DIV_DEFAULT = 13;
  localparam int         N_OUT               = 16;

  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

  // 0xFF is a true 100% duty, so it escapes the strict compare.
  function automatic logic pwm_wave_f(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    return (duty == PWM_DUTY_FULL) ? 1'b1 : (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: clk prescaler (0..CLK_DIV-1), free-running 8-bit step counter,
// and the single-cycle tick / wrap strobes derived from them.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  output logic     tick,
  output logic     wrap,
  output pwm_cnt_t pwm_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_div_cnt;
  pwm_cnt_t         r_pwm_cnt;

  assign tick    = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign wrap    = tick && (r_pwm_cnt == '1);
  assign pwm_cnt = r_pwm_cnt;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; the reset branch is in the sensitivity list, hence asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_pwm_cnt <= '0;
    end else if (tick) begin
      r_div_cnt <= '0;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin PWM peripheral: per-pin off / static high / shared PWM wave, registered outputs.
// Define PWM_SYNC_UPDATE_EN to shadow the duty register and apply changes only at period wrap.
module pwm_peripheral
#(
  parameter int CLK_DIV = pwm_pkg::PWM_CLK_DIV_DEFAULT,
  parameter int N_OUT   = pwm_pkg::N_OUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       en_reg_out_7_0,
  input  logic [7:0]       en_reg_out_15_8,
  input  logic [7:0]       en_reg_pwm_7_0,
  input  logic [7:0]       en_reg_pwm_15_8,
  input  logic [7:0]       pwm_duty_cycle,
  output logic [N_OUT-1:0] out,
  output logic             pwm_period_start
);

  import pwm_pkg::*;

  logic             w_tick;
  logic             w_wrap;
  logic             w_period_end;
  pwm_cnt_t         w_pwm_cnt;
  pwm_cnt_t         w_duty_act;
  logic             w_wave;
  logic [N_OUT-1:0] w_en_out;
  logic [N_OUT-1:0] w_en_pwm;
  logic [N_OUT-1:0] r_out;
  logic             r_period_start;

  pwm_timebase #(
    .CLK_DIV (CLK_DIV)
  ) u_timebase (
    .clk     (clk),
    .rst     (rst),
    .tick    (w_tick),
    .wrap    (w_wrap),
    .pwm_cnt (w_pwm_cnt)
  );

  // The 255 -> 0 step: a prescaler tick while the counter sits at its last value.
  assign w_period_end = w_tick & w_wrap;

`ifdef PWM_SYNC_UPDATE_EN
  pwm_cnt_t r_duty_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty_act <= '0;
    end else if (w_period_end) begin
      r_duty_act <= pwm_duty_cycle;
    end
  end

  assign w_duty_act = r_duty_act;
`else
  assign w_duty_act = pwm_duty_cycle;
`endif

  assign w_wave   = pwm_wave_f(w_pwm_cnt, w_duty_act);
  assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_out          <= w_en_out & (~w_en_pwm | {N_OUT{w_wave}});
      r_period_start <= w_period_end;
    end
  end

  assign out              = r_out;
  assign pwm_period_start = r_period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral: a time-based reference model predicts every
// registered output, a negedge monitor compares, directed phases measure high-times.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 13;
  localparam int PERIOD  = 256 * CLK_DIV;
`ifdef PWM_SYNC_UPDATE_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  e0, e1, p0, p1, duty;
  logic [15:0] out;
  logic        pstart;

  always #5 clk = ~clk;

  pwm_peripheral #(
    .CLK_DIV (CLK_DIV),
    .N_OUT   (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .en_reg_out_7_0   (e0),
    .en_reg_out_15_8  (e1),
    .en_reg_pwm_7_0   (p0),
    .en_reg_pwm_15_8  (p1),
    .pwm_duty_cycle   (duty),
    .out              (out),
    .pwm_period_start (pstart)
  );

  typedef struct packed {
    logic [15:0] out;
    logic        start;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned m_k      = 0;   // clk edges since reset release
  logic [7:0]  m_shadow = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: step index is elapsed edges / CLK_DIV; wrap every PERIOD edges.
  always @(posedge clk) begin : model
    exp_t       e;
    int         step;
    logic [7:0] d;
    logic       wave;
    e = '0;
    if (rst) begin
      m_k      = 0;
      m_shadow = 8'h00;
    end else begin
      step    = int'((m_k / CLK_DIV) % 256);
      d       = SYNC ? m_shadow : duty;
      wave    = (d == 8'hFF) || (step < int'(d));
      e.out   = {e1, e0} & (~{p1, p0} | {16{wave}});
      m_k     = m_k + 1;
      e.start = ((m_k % PERIOD) == 0);
      if (e.start) m_shadow = duty;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_out", 32'(out), 32'(e.out));
      check("sb_period_start", 32'(pstart), 32'(e.start));
    end
  end

  task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    {e1, e0} = eo;
    {p1, p0} = ep;
    duty     = d;
  endtask

  task automatic rand_cfg();
    set_cfg(16'($urandom), 16'($urandom), 8'($urandom));
  endtask

  // Returns at the negedge following the next wrap edge.
  task automatic wait_pulse();
    int cycles;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!pstart && cycles < 2 * PERIOD);
    if (!pstart) check("pulse_timeout", 32'(pstart), 32'd1);
  endtask

  // Counts negedges from release (cycle 1) until the first period pulse.
  task automatic first_pulse_check(input string name);
    int cyc;
    cyc = 1;
    do begin
      @(negedge clk);
      cyc++;
    end while (!pstart && cyc < 2 * PERIOD);
    check(name, 32'(cyc), 32'(PERIOD + 1));
  endtask

  initial begin
    int hi;
    int bad;
    logic [7:0] duties [3];
    duties[0] = 8'h80;
    duties[1] = 8'h00;
    duties[2] = 8'hFF;

    // Reset held with arbitrary configuration.
    rand_cfg();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_out", 32'(out), 32'h0);
    check("rst_period_start", 32'(pstart), 32'h0);
    #2 rst = 1'b0;
    first_pulse_check("first_pulse_cycle");

    // Static mode.
    set_cfg(16'hA5C3, 16'h0000, 8'($urandom));
    @(negedge clk);
    check("static_a5c3", 32'(out), 32'hA5C3);
    set_cfg(16'h0000, 16'h0000, 8'($urandom));
    @(negedge clk);
    check("static_off", 32'(out), 32'h0);

    // Single-pin high-time per full period for 50%, 0% and 100% duty.
    foreach (duties[n]) begin
      set_cfg(16'h0001, 16'h0001, duties[n]);
      wait_pulse();
      hi  = 0;
      bad = 0;
      for (int i = 0; i < PERIOD; i++) begin
        @(negedge clk);
        hi += int'(out[0]);
        if (out[15:1] != 15'h0) bad++;
      end
      check("pin0_high_time", 32'(hi), (duties[n] == 8'hFF) ? 32'(PERIOD) : 32'(int'(duties[n]) * CLK_DIV));
      check("pin0_others_low", 32'(bad), 32'h0);
    end

    // Mixed static/PWM pins at 25%.
    set_cfg(16'hFFFF, 16'h00FF, 8'h40);
    wait_pulse();
    hi  = 0;
    bad = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (out[15:8] != 8'hFF || (out[7:0] != 8'h00 && out[7:0] != 8'hFF)) bad++;
      if (out[7:0] == 8'hFF) hi++;
    end
    check("mixed_shape", 32'(bad), 32'h0);
    check("mixed_low_high_time", 32'(hi), 32'(64 * CLK_DIV));

    // Duty 0x40 -> 0xC0 written at step 0x10.
    set_cfg(16'h0001, 16'h0001, 8'h40);
    wait_pulse();
    hi = 0;
    for (int j = 1; j <= PERIOD; j++) begin
      @(negedge clk);
      hi += int'(out[0]);
      if (j == 16 * CLK_DIV) duty = 8'hC0;
    end
    check("duty_change_period", 32'(hi), SYNC ? 32'(64 * CLK_DIV) : 32'(192 * CLK_DIV));
    hi = 0;
    for (int j = 1; j <= PERIOD; j++) begin
      @(negedge clk);
      hi += int'(out[0]);
    end
    check("duty_next_period", 32'(hi), 32'(192 * CLK_DIV));

    // Asynchronous reset at step 0x7F.
    set_cfg(16'hFFFF, 16'h0000, 8'($urandom));
    wait_pulse();
    repeat (127 * CLK_DIV) @(negedge clk);
    check("pre_reset_out", 32'(out), 32'hFFFF);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", 32'(out), 32'h0);
    check("async_rst_period_start", 32'(pstart), 32'h0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    first_pulse_check("restart_first_pulse_cycle");

    // Randomized configuration traffic; every cycle checked by the scoreboard.
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if ($urandom_range(63) == 0) rand_cfg();
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
